// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// chooses the next PC (sequential, branch, jump, jr, interrupt, exception),
// runs a single-outstanding request/valid handshake with a variable-latency
// instruction memory, and discards wrong-path responses after a redirect.
//
// Optional build macro: IF_PERF_CNT_EN adds the perf_fetched and
// perf_discarded counter outputs.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   enable         hazard-unit advance enable (0 = stall)
//   branch_taken / branch_target, jump / jump_target, jr / jr_target,
//   interrupt, exception
//                  redirect requests (exception > interrupt > jr > jump > branch)
//   imem_req       memory request, held with imem_addr until imem_valid
//   imem_addr      request address
//   imem_rdata     returned instruction
//   imem_valid     imem_rdata valid; completes the outstanding request
//   Instruction    instruction to IF/ID (0 when no valid instruction)
//   PC, PC_plus_4  PC of the presented instruction and PC+4
//   fetch_valid    Instruction is a real instruction
//   IFIDMux        0 = IF/ID loads a bubble
//   fetch_stall    front end is waiting on memory
//   perf_fetched   (IF_PERF_CNT_EN) cycles with fetch_valid and enable
//   perf_discarded (IF_PERF_CNT_EN) memory responses dropped by redirects
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        interrupt,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        fetch_valid,
    output logic        IFIDMux,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded,
`endif
    output logic        fetch_stall
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] hold_reg, hold_nxt;
    logic [31:0] pc_inc;
    logic        redirect;
    logic [31:0] target;

    // Highest-priority redirect target, word aligned.
    function automatic logic [31:0] sel_target(
        input logic        exc,
        input logic        intr,
        input logic        jr_i,
        input logic        jmp_i,
        input logic [31:0] jr_t,
        input logic [31:0] jmp_t,
        input logic [31:0] br_t
    );
        logic [31:0] t;
        if (exc)        t = EXC_VECTOR;
        else if (intr)  t = INT_VECTOR;
        else if (jr_i)  t = jr_t;
        else if (jmp_i) t = jmp_t;
        else            t = br_t;
        return t & 32'hFFFF_FFFC;
    endfunction

    // Redirect inputs are masked while reset is held so the reset-state
    // outputs (IFIDMux=1, bubble) hold regardless of upstream control.
    assign redirect = reset & (exception | interrupt | jr | jump | branch_taken);
    assign target   = sel_target(exception, interrupt, jr, jump,
                                 jr_target, jump_target, branch_target);

    assign pc_inc    = pc + 32'd4;
    assign PC        = pc;
    assign PC_plus_4 = pc_inc;
    assign imem_addr = req_addr;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        hold_nxt     = hold_reg;
        imem_req     = 1'b0;
        fetch_valid  = 1'b0;
        Instruction  = 32'h0;
        IFIDMux      = 1'b1;
        fetch_stall  = 1'b0;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) pc_nxt = target;
                req_addr_nxt = pc_nxt;
            end
            FETCH: begin
                imem_req    = 1'b1;
                fetch_stall = ~imem_valid;
                if (redirect) begin
                    pc_nxt = target;
                    if (imem_valid) begin
                        // Response is wrong-path: drop it and refetch at once.
                        req_addr_nxt = target;
                    end else begin
                        // Request still in flight: keep its address stable and
                        // swallow the response before fetching the target.
                        state_nxt = DRAIN;
                    end
                end else if (imem_valid) begin
                    fetch_valid = 1'b1;
                    Instruction = imem_rdata;
                    if (enable) begin
                        pc_nxt       = pc_inc;
                        req_addr_nxt = pc_inc;
                    end else begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt       = target;
                    req_addr_nxt = target;
                    hold_nxt     = 32'h0;
                    state_nxt    = FETCH;
                end else begin
                    fetch_valid = 1'b1;
                    Instruction = hold_reg;
                    if (enable) begin
                        pc_nxt       = pc_inc;
                        req_addr_nxt = pc_inc;
                        state_nxt    = FETCH;
                    end
                end
            end
            DRAIN: begin
                imem_req    = 1'b1;
                fetch_stall = 1'b1;
                IFIDMux     = 1'b0;
                if (redirect) pc_nxt = target;
                if (imem_valid) begin
                    // pc_nxt already reflects a redirect arriving this cycle.
                    req_addr_nxt = pc_nxt;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (redirect) begin
            IFIDMux     = 1'b0;
            fetch_valid = 1'b0;
            Instruction = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            req_addr <= RESET_VECTOR;
            hold_reg <= 32'h0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            hold_reg <= hold_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic discard;

    // A response is dropped when it lands together with a redirect in FETCH
    // or at any time during DRAIN.
    assign discard = imem_valid & (((state == FETCH) & redirect) | (state == DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched   <= 32'h0;
            perf_discarded <= 32'h0;
        end else begin
            if (fetch_valid & enable) perf_fetched <= perf_fetched + 32'd1;
            if (discard)              perf_discarded <= perf_discarded + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    localparam logic [4:0] R_EXC = 5'b10000;
    localparam logic [4:0] R_INT = 5'b01000;
    localparam logic [4:0] R_JR  = 5'b00100;
    localparam logic [4:0] R_JMP = 5'b00010;
    localparam logic [4:0] R_BR  = 5'b00001;
    localparam logic [4:0] R_NONE = 5'b00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
    logic        interrupt = 1'b0, exception = 1'b0;
    logic [31:0] branch_target = 32'h0, jump_target = 32'h0, jr_target = 32'h0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr, Instruction, PC, PC_plus_4;
    logic        fetch_valid, IFIDMux, fetch_stall;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded;
    logic [31:0] disc0;
`endif

    int checks = 0;
    int fails  = 0;
    int consumed = 0;

    // Reference model state: PC of the next instruction that must be delivered,
    // and the queue of redirect targets issued by the stimulus.
    logic [31:0] exp_pc = RV;
    logic [31:0] redir_q[$];

    // Memory model state.
    int          lat_mode = 1;   // 0 = random 1..3 cycles per request
    int          wait_cnt = 0;
    int          cur_lat = 1;
    logic        out_active = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] out_addr = 32'h0;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .enable(enable),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target),
        .interrupt(interrupt), .exception(exception),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .Instruction(Instruction), .PC(PC), .PC_plus_4(PC_plus_4),
        .fetch_valid(fetch_valid), .IFIDMux(IFIDMux),
`ifdef IF_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_discarded(perf_discarded),
`endif
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h2008_0005;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_3C3C;
    endfunction

    // Target selected by the redirect priority rule, low two bits cleared.
    function automatic logic [31:0] model_target(input logic [4:0] rs, input logic [31:0] bt,
                                                 input logic [31:0] jt, input logic [31:0] rt);
        logic [31:0] t;
        if (rs[4])      t = EV;
        else if (rs[3]) t = IV;
        else if (rs[2]) t = rt;
        else if (rs[1]) t = jt;
        else            t = bt;
        return {t[31:2], 2'b00};
    endfunction

    // Memory responder, evaluated once per cycle just after the rising edge.
    task automatic mem_step();
        if (!reset) begin
            out_active = 1'b0;
            mem_done   = 1'b0;
            imem_valid = 1'b0;
            imem_rdata = 32'h0;
            return;
        end
        if (mem_done) out_active = 1'b0;
        mem_done = 1'b0;
        if (imem_req) begin
            if (!out_active) begin
                out_active = 1'b1;
                out_addr   = imem_addr;
                wait_cnt   = 0;
                cur_lat    = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            end else begin
                chk("imem_addr_stable", imem_addr, out_addr);
            end
            imem_valid = (wait_cnt >= cur_lat - 1);
            imem_rdata = mem_word(imem_addr);
            wait_cnt++;
            mem_done = imem_valid;
        end else begin
            if (out_active) begin
                chk1("imem_req_held", imem_req, 1'b1);
                out_active = 1'b0;
            end
            // Stray valids while no request is open must be ignored.
            imem_valid = ($urandom_range(0, 3) == 0);
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic tick(input logic en, input logic [4:0] rs, input logic [31:0] bt,
                        input logic [31:0] jt, input logic [31:0] rt);
        @(posedge clk);
        #1;
        mem_step();
        enable = en;
        {exception, interrupt, jr, jump, branch_taken} = rs;
        branch_target = bt;
        jump_target   = jt;
        jr_target     = rt;
        if (rs != R_NONE) redir_q.push_back(model_target(rs, bt, jt, rt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] rs;
            rs = R_NONE;
            if ($urandom_range(0, 99) < 8) rs = 5'($urandom_range(1, 31));
            tick($urandom_range(0, 3) != 0, rs, $urandom, $urandom, $urandom);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk1("rst_imem_req", imem_req, 1'b0);
            chk1("rst_fetch_valid", fetch_valid, 1'b0);
            chk1("rst_ifidmux", IFIDMux, 1'b1);
            chk1("rst_fetch_stall", fetch_stall, 1'b0);
            chk("rst_instruction", Instruction, 32'h0);
            chk("rst_pc", PC, RV);
            redir_q.delete();
            exp_pc = RV;
        end else begin
            if (exception | interrupt | jr | jump | branch_taken) begin
                chk1("redir_fetch_valid", fetch_valid, 1'b0);
                chk1("redir_ifidmux", IFIDMux, 1'b0);
                if (redir_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL redir_queue: got empty queue, expected a pending target");
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end else if (fetch_valid) begin
                chk("pc", PC, exp_pc);
                chk("pc_plus_4", PC_plus_4, exp_pc + 32'd4);
                chk("instruction", Instruction, mem_word(exp_pc));
                chk1("valid_ifidmux", IFIDMux, 1'b1);
                if (enable) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
            end else begin
                chk("bubble_instruction", Instruction, 32'h0);
            end
            if (imem_req && !imem_valid) chk1("stall_waiting", fetch_stall, 1'b1);
            if (!imem_req) chk1("stall_no_req", fetch_stall, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nst, nvl;
        #1 reset = 1'b0;
        repeat (3) tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        run(20);
        lat_mode = 0;
        random_phase(400);

        // Reset mid-run, then zero-wait restart from the reset vector.
        lat_mode = 1;
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        repeat (2) tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk1("idle_fetch_valid", fetch_valid, 1'b0);
        chk1("idle_imem_req", imem_req, 1'b0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("boot_addr0", imem_addr, 32'h0);
        chk("boot_pc_plus_4", PC_plus_4, 32'h4);
        chk1("boot_fetch_valid", fetch_valid, 1'b1);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("boot_addr1", imem_addr, 32'h4);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("boot_addr2", imem_addr, 32'h8);

        // Three-cycle memory: two stall cycles per delivered instruction.
        run(2);
        lat_mode = 3;
        nst = 0;
        nvl = 0;
        repeat (9) begin
            tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            nst += int'(fetch_stall);
            nvl += int'(fetch_valid);
        end
        chk("lat3_stall_cycles", 32'(nst), 32'd6);
        chk("lat3_valid_cycles", 32'(nvl), 32'd3);

        // Stall while a response arrives: instruction parks in HOLD.
        lat_mode = 1;
        run(4);
        tick(1'b1, R_JMP, 32'h0, 32'h300, 32'h0);
        tick(1'b0, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("hold_capture", Instruction, 32'h2008_0005);
        repeat (3) begin
            tick(1'b0, R_NONE, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk("hold_instr", Instruction, 32'h2008_0005);
            chk("hold_pc", PC, 32'h300);
            chk1("hold_no_req", imem_req, 1'b0);
        end
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("hold_next_addr", imem_addr, 32'h304);

        // Branch while a request for 0x10 is outstanding.
        tick(1'b1, R_JMP, 32'h0, 32'h10, 32'h0);
        lat_mode = 3;
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("drain_req_addr", imem_addr, 32'h10);
`ifdef IF_PERF_CNT_EN
        disc0 = perf_discarded;
`endif
        tick(1'b1, R_BR, 32'h40, 32'h0, 32'h0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("drain_resp_arrives", imem_valid, 1'b1);
        chk1("drain_ifidmux", IFIDMux, 1'b0);
        chk1("drain_fetch_valid", fetch_valid, 1'b0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("drain_next_addr", imem_addr, 32'h40);
`ifdef IF_PERF_CNT_EN
        chk("perf_discarded_step", perf_discarded, disc0 + 32'd1);
`endif

        // Redirect priority and target alignment.
        lat_mode = 1;
        run(4);
        tick(1'b1, R_EXC | R_JR | R_BR, 32'h200, 32'h0, 32'h100);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("prio_exc_pc", PC, EV);
        tick(1'b1, R_JR, 32'h0, 32'h0, 32'h103);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("jr_align_pc", PC, 32'h100);

        // PC wrap at the top of the address space.
        tick(1'b1, R_JMP, 32'h0, 32'hFFFF_FFFC, 32'h0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pc_plus_4", PC_plus_4, 32'h0);
        tick(1'b1, R_NONE, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'h0);

        lat_mode = 0;
        random_phase(400);
        lat_mode = 1;
        run(6);
        @(negedge clk);
        chk1("progress", consumed > 300, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC register, selects next PC (sequential / branch / jump / jr / interrupt / exception), runs a request/valid handshake with a variable-latency instruction memory, and drives Instruction, PC, PC_plus_4 and the active-low IFIDMux flush into IF/ID. Wrong-path fetches are discarded safely on redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
INT_VECTOR, 32'h8000_0004, interrupt target
EXC_VECTOR, 32'h8000_0008, exception target

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  PC advance enable from hazard unit; 0 = stall
branch_taken  in  1  branch redirect
branch_target  in  32  branch target
jump  in  1  J/JAL redirect
jump_target  in  32  jump target
jr  in  1  JR/JALR redirect
jr_target  in  32  register target
interrupt  in  1  interrupt redirect
exception  in  1  exception redirect
imem_req  out  1  memory request
imem_addr  out  32  request address
imem_rdata  in  32  returned instruction
imem_valid  in  1  imem_rdata valid; completes the outstanding request
Instruction  out  32  to IF/ID
PC  out  32  PC of presented instruction
PC_plus_4  out  32  PC+4
fetch_valid  out  1  Instruction is real
IFIDMux  out  1  0 = IF/ID loads a bubble
fetch_stall  out  1  1 = front end waiting on memory

Behaviour:
- Reset (reset=0, async): PC=RESET_VECTOR, state IDLE, imem_req=0, fetch_valid=0, IFIDMux=1, Instruction=0, fetch_stall=0, all internal registers cleared.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: one cycle after reset release, then FETCH.
- Handshake: imem_req=1 in FETCH and DRAIN. imem_addr and imem_req stay stable until the cycle imem_valid=1. imem_addr comes from a separate req_addr register. One outstanding request at most. imem_valid outside FETCH/DRAIN is ignored.
- FETCH, imem_valid=0: fetch_valid=0, fetch_stall=1.
- FETCH, imem_valid=1, enable=1: Instruction=imem_rdata combinationally, fetch_valid=1. At the edge, PC and req_addr advance to PC+4 and the state stays FETCH. Back-to-back zero-wait fetches sustain 1 instr/cycle.
- FETCH, imem_valid=1, enable=0: capture imem_rdata into hold_reg and go to HOLD.
- HOLD: imem_req=0. Present hold_reg with fetch_valid=1. When enable=1, PC advances by 4 and the state returns to FETCH.
- Redirect = OR of the five redirect inputs.
  - Priority: exception > interrupt > jr > jump > branch_taken.
  - Target bits [1:0] are forced to 0.
  - A redirect applies regardless of enable.
  - In the redirect cycle, IFIDMux=0 and fetch_valid=0.
- Redirect per state:
  - FETCH with imem_valid=1: discard the response; PC and req_addr take the target; stay in FETCH.
  - FETCH with imem_valid=0: PC takes the target; go to DRAIN; req_addr is unchanged.
  - HOLD: drop hold_reg; PC and req_addr take the target; go to FETCH.
  - DRAIN: PC takes the newest target.
  - IDLE: PC takes the target.
- DRAIN: IFIDMux=0, fetch_valid=0, fetch_stall=1. When imem_valid=1, discard the data, set req_addr=PC and go to FETCH.
- PC_plus_4 = PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- When fetch_valid=0 and no redirect: IFIDMux=1 and Instruction=0 (NOP bubble).

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds two 32-bit outputs, perf_fetched and perf_discarded.
  - perf_fetched counts cycles with fetch_valid=1 and enable=1.
  - perf_discarded counts memory responses dropped due to a redirect (FETCH+valid+redirect, or valid in DRAIN).
  - Both counters wrap and are cleared by reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset low mid-run, then release; zero-wait memory -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; PC_plus_4=0x4 with PC=0x0; fetch_valid=1 from the second cycle after release.
- 3-cycle memory latency -> fetch_stall=1 for 2 cycles per fetch; imem_addr is stable throughout; one valid instruction per 3 cycles.
- enable=0 while imem_valid=1 with rdata 0x2008_0005 -> HOLD; Instruction stays 0x2008_0005 and PC stays constant for the stall; after enable=1 the next imem_addr is PC+4.
- branch_taken=1 to 0x40 while a request for 0x10 is outstanding -> DRAIN; the response for 0x10 is dropped with IFIDMux=0; the next request is 0x40.
- exception, jr(0x100) and branch(0x200) in the same cycle -> PC=EXC_VECTOR; jr_target 0x103 alone -> PC=0x100.
- PC=0xFFFF_FFFC -> PC_plus_4=0; the next fetch address is 0x0; with IF_PERF_CNT_EN, perf_discarded increments by exactly 1 per dropped response.
